// File: rtl/alu_pkg.sv
// Shared ALU definitions: bitwise op encoding and pipeline reset values.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;
  localparam op_t OP_ACC  = 3'd7;

  // Flag values for the empty result register (r = 0).
  localparam logic RST_VALID  = 1'b0;
  localparam logic RST_ZERO   = 1'b1;
  localparam logic RST_PARITY = 1'b0;

endpackage

// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for the bitwise logic pipe.
interface bitwise_logic_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             parity;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;

  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, r, zero, parity, acc, acc_cnt
  );

  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, r, zero, parity, acc, acc_cnt
  );
endinterface

// File: rtl/bitwise_op_comb.sv
// Combinational bitwise op decode; ACC folds both operands into acc_in.
module bitwise_op_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_ACC:  r = acc_in ^ a ^ b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit with running XOR accumulator.
module bitwise_logic_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  bitwise_logic_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_v;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_v;
  logic [WIDTH-1:0] r_q;
  logic             zero_q;
  logic             parity_q;

  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_ready;
  logic             s1_load;
  logic             s2_load;
  logic             acc_fold;
  logic [WIDTH-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [WIDTH-1:0] r_next;

  assign in_ready = !s1_v || !s2_v || bus.out_ready;
  assign s2_load  = s1_v && (!s2_v || bus.out_ready);
  assign s1_load  = bus.in_valid && in_ready;
  assign acc_fold = s2_load && (s1_op == OP_ACC);

  // A coincident clear is applied before the fold sees the accumulator.
  assign acc_base = bus.acc_clr ? '0 : acc_q;
  assign cnt_base = bus.acc_clr ? '0 : cnt_q;

  bitwise_op_comb #(.WIDTH(WIDTH)) u_op (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .acc_in (acc_base),
    .r      (r_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= RST_VALID;
    end else if (s1_load) begin
      s1_v <= 1'b1;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_op <= bus.op;
      s1_a  <= bus.a;
      s1_b  <= bus.b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= RST_VALID;
      r_q      <= '0;
      zero_q   <= RST_ZERO;
      parity_q <= RST_PARITY;
    end else if (s2_load) begin
      s2_v     <= 1'b1;
      r_q      <= r_next;
      zero_q   <= (r_next == '0);
      parity_q <= ^r_next;
    end else if (bus.out_ready) begin
      s2_v     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (acc_fold) begin
      acc_q <= r_next;
      cnt_q <= cnt_base + CNT_ONE;
    end else if (bus.acc_clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_v;
  assign bus.r         = r_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.acc       = acc_q;
  assign bus.acc_cnt   = cnt_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed bench for bitwise_logic_pipe: ops, stall, accumulator, reset, wrap.
module tb_bitwise_logic_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [15:0] got [8];
  int   n_got;
  int   n_stale;

  always #5 clk = ~clk;

  bitwise_logic_pipe_if #(.WIDTH(16), .CNT_W(8)) bus ();

  bitwise_logic_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    else
      n_pass++;
  endtask

  task automatic drive(input op_t op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = OP_AND;
    bus.a         = '0;
    bus.b         = '0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_r",         32'(bus.r),         0);
    chk("rst_zero",      32'(bus.zero),      1);
    chk("rst_parity",    32'(bus.parity),    0);
    chk("rst_acc",       32'(bus.acc),       0);
    chk("rst_acc_cnt",   32'(bus.acc_cnt),   0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready",  32'(bus.in_ready),  1);

    // XOR latency: accepted at first edge, visible after the second
    drive(OP_XOR, 16'h00F8, 16'h0147);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("xor_lat1_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("xor_valid",  32'(bus.out_valid), 1);
    chk("xor_r",      32'(bus.r),         32'h01BF);
    chk("xor_zero",   32'(bus.zero),      0);
    chk("xor_parity", 32'(bus.parity),    0);

    // AND then NAND back to back
    drive(OP_AND, 16'h00F8, 16'h0147);
    @(negedge clk);
    drive(OP_NAND, 16'h00F8, 16'h0147);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("and_r",       32'(bus.r),      32'h0040);
    chk("and_parity",  32'(bus.parity), 1);
    @(negedge clk);
    chk("nand_valid",  32'(bus.out_valid), 1);
    chk("nand_r",      32'(bus.r),      32'hFFBF);
    chk("nand_parity", 32'(bus.parity), 1);
    @(negedge clk);
    chk("drain_valid", 32'(bus.out_valid), 0);

    // Stall: three beats offered, downstream blocked for five cycles
    bus.out_ready = 1'b0;
    drive(OP_OR, 16'h000F, 16'h00F0);
    @(negedge clk);
    chk("stall_ready1", 32'(bus.in_ready), 1);
    drive(OP_XOR, 16'hAAAA, 16'h5555);
    @(negedge clk);
    drive(OP_AND, 16'hFF00, 16'h0FF0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready",  32'(bus.in_ready),  0);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_r_held",    32'(bus.r),         32'h00FF);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    n_got = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.in_valid = 1'b0;
      if (bus.out_valid && bus.out_ready && n_got < 8) begin
        got[n_got] = bus.r;
        n_got++;
      end
      @(negedge clk);
    end
    chk("stall_count", 32'(n_got), 3);
    chk("stall_b1", 32'(got[0]), 32'h00FF);
    chk("stall_b2", 32'(got[1]), 32'hFFFF);
    chk("stall_b3", 32'(got[2]), 32'h0F00);

    // Accumulator folds back to back
    drive(OP_ACC, 16'h1234, 16'h0000);
    @(negedge clk);
    drive(OP_ACC, 16'h00FF, 16'h0000);
    @(negedge clk);
    chk("acc1_r",   32'(bus.r),   32'h1234);
    chk("acc1_acc", 32'(bus.acc), 32'h1234);
    drive(OP_ACC, 16'h1234, 16'h0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("acc2_acc", 32'(bus.acc), 32'h12CB);
    @(negedge clk);
    chk("acc3_acc", 32'(bus.acc),     32'h00FF);
    chk("acc3_r",   32'(bus.r),       32'h00FF);
    chk("acc3_cnt", 32'(bus.acc_cnt), 3);

    // Clear coincident with an ACC fold
    drive(OP_ACC, 16'h0001, 16'h0010);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b1;
    @(negedge clk);
    bus.acc_clr  = 1'b0;
    chk("clr_acc", 32'(bus.acc),     32'h0011);
    chk("clr_r",   32'(bus.r),       32'h0011);
    chk("clr_cnt", 32'(bus.acc_cnt), 1);
    @(negedge clk);

    // Reset with both stages full (ACC beat sitting in S1)
    bus.out_ready = 1'b0;
    drive(OP_XOR, 16'h0001, 16'h0002);
    @(negedge clk);
    drive(OP_ACC, 16'h5555, 16'h0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_full", 32'(bus.in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("mid_rst_valid",  32'(bus.out_valid), 0);
    chk("mid_rst_acc",    32'(bus.acc),       0);
    chk("mid_rst_cnt",    32'(bus.acc_cnt),   0);
    chk("mid_rst_r",      32'(bus.r),         0);
    chk("mid_rst_zero",   32'(bus.zero),      1);
    chk("mid_rst_parity", 32'(bus.parity),    0);
    n_stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) n_stale++;
    end
    chk("mid_rst_stale", 32'(n_stale), 0);
    chk("mid_rst_acc_after", 32'(bus.acc), 0);

    // NOT ignores b
    drive(OP_NOT, 16'hFFFF, 16'h1234);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("not_valid",  32'(bus.out_valid), 1);
    chk("not_r",      32'(bus.r),         0);
    chk("not_zero",   32'(bus.zero),      1);
    chk("not_parity", 32'(bus.parity),    0);
    @(negedge clk);

    // Fold counter wrap: XOR of 0..254 is 0xFF, of 0..255 is 0
    for (int i = 0; i < 255; i++) begin
      drive(OP_ACC, 16'(i), 16'h0000);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_cnt_255", 32'(bus.acc_cnt), 255);
    chk("wrap_acc_255", 32'(bus.acc),     32'h00FF);
    drive(OP_ACC, 16'h00FF, 16'h0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_cnt_0", 32'(bus.acc_cnt), 0);
    chk("wrap_acc_0", 32'(bus.acc),     0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, pipelined bitwise logic unit for the ALU datapath. Applies one of eight selectable bitwise operations to two WIDTH-bit operands, or folds operands into a running XOR accumulator for checksum and parity work. It uses valid/ready handshakes on both sides and a two-stage pipeline. Zero and parity flags travel with each result.

## Interface
- WIDTH, 16, operand/result width (≥2)
- CNT_W, 8, width of accumulate-fold counter

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  unit accepts beat this cycle
- op  in  3  operation select (see Operation)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- acc_clr  in  1  clear accumulator and fold counter
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- r  out  WIDTH  result
- zero  out  1  r == 0
- parity  out  1  XOR-reduction of r
- acc  out  WIDTH  current accumulator value
- acc_cnt  out  CNT_W  number of ACC folds since clear, wraps modulo 2^CNT_W

## Operation
- op encoding:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 NOT (~a, b ignored)
  - 7 ACC (acc ^ a ^ b)
- Stage 1 (S1) registers op, a, b on handshake (in_valid && in_ready).
- Stage 2 (S2) computes r, zero, parity from S1 contents when S1 advances into S2.
- For op 7:
  - acc is updated to the new value and r carries it.
  - acc_cnt increments, wrapping.
- acc updates only at the S1→S2 transfer of an op-7 beat. Back-to-back ACC beats therefore see each other's result with no hazard.
- Stage advance rules:
  - S2 loads when S1 valid and (S2 empty or out_ready).
  - S1 loads when in_valid and (S1 empty or S1 advancing).
- in_ready = !s1_v || !s2_v || out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
- acc_clr:
  - Takes effect at the clock edge it is sampled, independent of handshakes.
  - If it coincides with an op-7 transfer, clear applies first: acc ← a ^ b, acc_cnt ← 1.
  - It does not flush beats in flight.
- Flags are registered with r and held stable while out_valid && !out_ready.

## Timing
- Latency: 2 cycles from input handshake to out_valid with an unstalled pipeline. Throughput is 1 beat/cycle.
- Reset (synchronous, rst high at edge):
  - s1_v = s2_v = 0, out_valid = 0
  - r = 0, zero = 1, parity = 0
  - acc = 0, acc_cnt = 0
  - in_ready = 1 the cycle after reset releases; it is 1 during reset only via combinational rule, and no beat is accepted while rst is high.
- Reset mid-operation drops all in-flight beats without emitting them. An ACC beat in S1 does not update acc.
- Stall: r, zero, parity and out_valid stay constant while out_ready = 0. With both stages full, in_ready = 0.
- Simultaneous out handshake and S1 advance in the same cycle: S2 reloads with no bubble.
- acc_cnt wraps from 2^CNT_W−1 to 0.

## Structure
- Shared package `alu_pkg` holds:
  - the op encoding constants (OP_AND … OP_ACC), 3-bit op typedef
  - the reset value constants
- Sub-module `bitwise_op_comb`: purely combinational op decode, computing r from op/a/b/acc_in. The top instantiates it in S2. It replaces the existing single-function XOR gate for all bitwise uses.
- Top holds the stage registers, handshake logic, accumulator and counter.

## Test plan
- WIDTH=16, XOR a=248 (0x00F8), b=327 (0x0147), out_ready=1 → r=0x01BF (447) two cycles later, zero=0, parity=0.
- AND, then NAND, same operands back to back → r=0x0040 then r=0xFFBF on consecutive cycles, parity 1 then 1.
- Stall handling:
  - Stimulus: out_ready=0 for 5 cycles with 3 beats offered.
  - Required: in_ready drops after 2 accepted, r held constant.
  - Then out_ready=1: all 3 results emerge in order, none lost or duplicated.
- Accumulator:
  - Stimulus: ACC beats (a,b) = (0x1234,0), (0x00FF,0), (0x1234,0).
  - Required: acc = 0x1234, 0x12CB, 0x00FF; acc_cnt = 3.
  - Then acc_clr coincident with ACC (0x0001,0x0010) → acc=0x0011, acc_cnt=1.
- Reset mid-stream:
  - Stimulus: rst asserted while both stages hold beats.
  - Required: next cycle out_valid=0, acc=0, acc_cnt=0, r=0, zero=1, no stale beat emitted after release.
- NOT a=0xFFFF, b=0x1234 → r=0, zero=1, parity=0; acc_cnt wraps 255→0 after 256 ACC beats with CNT_W=8.
